can_rx_frame_seq: RTL and testbench
===================================

# can_rx_frame_seq

Receive-side frame sequencer for classic CAN standard-ID frames; sits between the bit-sampling front end and the message buffer. Consumes one sampled bus bit per `bit_valid` strobe, removes stuff bits, tracks frame fields, steps an enabled CRC-15 engine over SOF..data and checks the received CRC field. Reports ID, DLC, CRC result and stuff/form errors per frame.

## Interface
- `CRC_BITS`, 15: CRC width.
- `POLY`, 15'h4599: CRC generator, x^15 term implicit.
- `IDLE_BITS`, 11: consecutive recessive bits required before SOF is accepted.
- `clk`  in  1  sole clock. All logic is on posedge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `bit_valid`  in  1  one-cycle strobe, one sampled bus bit; back-to-back strobes legal.
- `rx_bit`  in  1  sampled bit, 0 = dominant; qualified by `bit_valid`.
- `busy`  out  1  high from SOF until the frame ends or aborts.
- `frame_done`  out  1  one-cycle pulse, frame ended at the CRC delimiter (good or bad CRC).
- `crc_ok`  out  1  computed CRC == received CRC; valid with `frame_done`, held until next SOF.
- `id`  out  11  received identifier, held until next SOF.
- `dlc`  out  4  received DLC, raw value, held until next SOF.
- `stuff_err`  out  1  one-cycle pulse, six equal consecutive bits inside the stuffed region.
- `form_err`  out  1  one-cycle pulse, dominant CRC delimiter or IDE=1.

## Operation
- Process bits only on `bit_valid`. With `bit_valid` low, all state holds.
- States: `WAIT_IDLE`, `IDLE`, `ARB`, `CTRL`, `DATA`, `CRC`, `DELIM`.
  - `WAIT_IDLE`: count consecutive 1 bits; a 0 clears the count; at `IDLE_BITS` go to `IDLE`.
  - `IDLE`: a 0 is SOF: clear CRC and stuff state, step CRC with the 0, go to `ARB`.
  - `ARB`: 11 ID bits MSB first, then RTR (12 bits), then `CTRL`.
  - `CTRL`: IDE, r0, then DLC[3:0] MSB first (6 bits).
    - IDE=1 pulses `form_err` and goes to `WAIT_IDLE`.
  - After DLC, go to `DATA`. Payload bits = 8*min(dlc,8), or 0 if RTR=1. A zero payload goes directly to `CRC`.
  - `CRC`: shift 15 destuffed bits into the received-CRC register; the CRC engine does not step.
  - `DELIM`: a 1 pulses `frame_done`, with `crc_ok` = (crc == rx_crc). A 0 pulses `form_err`, with no `frame_done`. Both go to `WAIT_IDLE`.
    - The dominant ACK slot therefore cannot be taken as SOF.
- CRC step on every non-stuff bit from SOF to the last data bit: crc <= {crc[13:0],0} ^ ((crc[14]^bit) ? POLY : 0). Initial value 0.
- Destuffing covers SOF through the last CRC bit.
  - Track the last value and a run count of 1..5.
  - When the run reaches 5, the next bit is a stuff bit. If it differs from the last value: discard it (no field advance, no CRC step) and restart the run at 1 with its value. If it equals the last value: pulse `stuff_err` and go to `WAIT_IDLE`.
  - The delimiter is not destuffed.
- Field-bit counter is 7 bits (max 64 payload bits).

## Timing
- Reset values: state `WAIT_IDLE` with idle count 0; `busy`, `frame_done`, `crc_ok`, `stuff_err`, `form_err` = 0; `id` = 0; `dlc` = 0.
- All outputs are registered. Pulses assert in the cycle after the `bit_valid` that caused them, and last exactly one cycle.
- `busy` rises the cycle after SOF and falls together with the `frame_done`/error pulse.
- `id` and `dlc` update progressively during reception. `crc_ok` clears at SOF.
- `rst_n` asserted mid-frame aborts immediately, with no pulses. After release the block needs `IDLE_BITS` recessive bits before accepting SOF.
- Errors and done are mutually exclusive per frame.

## Structure
- Shared package `can_pkg` holds:
  - the state enum;
  - constants `CAN_CRC_POLY`, `CAN_IDLE_BITS`, `CAN_STUFF_LEN` = 5, `CAN_ID_BITS` = 11.
- One sub-module, `can_crc15_step`: `clk`, `rst_n`, `clr`, `en`, `din`, `crc[14:0]`, stepping only when `en` is high. It replaces a free-running shift so the sequencer can gate stuff bits.

## Test plan
- 11×1, then ID=0x000, RTR=0, DLC=0, CRC=0x0000, sent with stuffing (a 1 after every five 0s, including inside CRC), then delimiter 1 -> `frame_done`=1, `crc_ok`=1, `id`=0x000, `dlc`=0.
- Same frame with one received CRC bit flipped and stuffing kept legal -> `frame_done`=1, `crc_ok`=0.
- Six 0s starting at SOF (stuff bit omitted) -> `stuff_err` pulse on the 6th bit, `busy`=0, no `frame_done`.
- Valid frame ID=0x7FF, DLC=1, data 0xA5, CRC from reference model, delimiter sent as 0 -> `form_err` pulse, no `frame_done`; an immediately following SOF is ignored until 11 recessive bits.
- Frame with IDE=1 -> `form_err` at the IDE bit. Frame with DLC=15, RTR=0 -> exactly 64 data bits consumed.
- `rst_n` low mid-`DATA` -> all outputs 0. An SOF sent right after release is ignored. After 11×1, a valid frame is received with `crc_ok`=1.

Source files
------------

// File: rtl/can_pkg.sv
// Shared CAN receive definitions: sequencer states, protocol constants and payload sizing.
package can_pkg;

  typedef enum logic [2:0] {
    WAIT_IDLE,
    IDLE,
    ARB,
    CTRL,
    DATA,
    CRC,
    DELIM
  } can_state_t;

  localparam logic [14:0] CAN_CRC_POLY  = 15'h4599;
  localparam int          CAN_IDLE_BITS = 11;
  localparam int          CAN_STUFF_LEN = 5;
  localparam int          CAN_ID_BITS   = 11;

  // Remote frames carry no payload; DLC values above 8 still mean 8 bytes.
  function automatic logic [6:0] payload_bits(input logic [3:0] dlc_v, input logic rtr_v);
    if (rtr_v) return 7'd0;
    if (dlc_v > 4'd8) return 7'd64;
    return {dlc_v, 3'b000};
  endfunction

endpackage

// File: rtl/can_crc15_step.sv
// CRC-15 register that advances one bit only when enabled, so stuff bits can be skipped.
// One cycle per step; clr together with en restarts from zero and steps the new bit in.
module can_crc15_step
  import can_pkg::*;
#(
  parameter logic [14:0] POLY = CAN_CRC_POLY
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        en,
  input  logic        din,
  output logic [14:0] crc
);

  logic [14:0] base;

  assign base = clr ? 15'h0 : crc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crc <= 15'h0;
    end else if (en) begin
      crc <= {base[13:0], 1'b0} ^ ((base[14] ^ din) ? POLY : 15'h0);
    end else if (clr) begin
      crc <= 15'h0;
    end
  end

endmodule

// File: rtl/can_rx_frame_seq.sv
// CAN standard-frame receive sequencer: destuffs, tracks fields, checks CRC-15.
// Outputs registered one cycle after the causing bit_valid; no backpressure, bits are consumed as strobed.
module can_rx_frame_seq
  import can_pkg::*;
#(
  parameter int                  CRC_BITS  = 15,
  parameter logic [CRC_BITS-1:0] POLY      = CAN_CRC_POLY,
  parameter int                  IDLE_BITS = CAN_IDLE_BITS
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   bit_valid,
  input  logic                   rx_bit,
  output logic                   busy,
  output logic                   frame_done,
  output logic                   crc_ok,
  output logic [CAN_ID_BITS-1:0] id,
  output logic [3:0]             dlc,
  output logic                   stuff_err,
  output logic                   form_err
);

  localparam int IW = $clog2(IDLE_BITS + 1);

  can_state_t          state;
  logic [IW-1:0]       idle_cnt;
  logic [6:0]          cnt;
  logic [6:0]          pay_len;
  logic                last_bit;
  logic [2:0]          run_cnt;
  logic                rtr;
  logic [CRC_BITS-1:0] rx_crc;
  logic [CRC_BITS-1:0] crc_val;

  logic       stuffed_st;
  logic       stuff_bit;
  logic       sof;
  logic       crc_en;
  logic [6:0] next_len;

  assign stuffed_st = state inside {ARB, CTRL, DATA, CRC};
  assign stuff_bit  = stuffed_st && (run_cnt == 3'(CAN_STUFF_LEN));
  assign sof        = bit_valid && (state == IDLE) && !rx_bit;
  assign crc_en     = bit_valid && !stuff_bit && (sof || (state inside {ARB, CTRL, DATA}));
  assign next_len   = payload_bits({dlc[2:0], rx_bit}, rtr);

  can_crc15_step #(
    .POLY (POLY)
  ) u_crc (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (sof),
    .en    (crc_en),
    .din   (rx_bit),
    .crc   (crc_val)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= WAIT_IDLE;
      idle_cnt   <= '0;
      cnt        <= 7'd0;
      pay_len    <= 7'd0;
      last_bit   <= 1'b0;
      run_cnt    <= 3'd0;
      rtr        <= 1'b0;
      rx_crc     <= '0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      crc_ok     <= 1'b0;
      id         <= '0;
      dlc        <= 4'd0;
      stuff_err  <= 1'b0;
      form_err   <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      stuff_err  <= 1'b0;
      form_err   <= 1'b0;
      if (bit_valid) begin
        unique case (state)
          WAIT_IDLE: begin
            if (!rx_bit) begin
              idle_cnt <= '0;
            end else if (idle_cnt == IW'(IDLE_BITS - 1)) begin
              idle_cnt <= '0;
              state    <= IDLE;
            end else begin
              idle_cnt <= idle_cnt + 1'b1;
            end
          end
          IDLE: begin
            if (!rx_bit) begin
              state    <= ARB;
              busy     <= 1'b1;
              crc_ok   <= 1'b0;
              id       <= '0;
              dlc      <= 4'd0;
              cnt      <= 7'd0;
              last_bit <= 1'b0;
              run_cnt  <= 3'd1;
            end
          end
          DELIM: begin
            busy     <= 1'b0;
            state    <= WAIT_IDLE;
            idle_cnt <= '0;
            if (rx_bit) begin
              frame_done <= 1'b1;
              crc_ok     <= (crc_val == rx_crc);
            end else begin
              form_err <= 1'b1;
            end
          end
          default: begin
            if (stuff_bit) begin
              // A stuff bit must break the run; an equal sixth bit is a stuff violation.
              if (rx_bit != last_bit) begin
                last_bit <= rx_bit;
                run_cnt  <= 3'd1;
              end else begin
                stuff_err <= 1'b1;
                busy      <= 1'b0;
                state     <= WAIT_IDLE;
                idle_cnt  <= '0;
              end
            end else begin
              if (rx_bit == last_bit) begin
                run_cnt <= run_cnt + 3'd1;
              end else begin
                run_cnt  <= 3'd1;
                last_bit <= rx_bit;
              end
              case (state)
                ARB: begin
                  if (cnt == 7'(CAN_ID_BITS)) begin
                    rtr   <= rx_bit;
                    cnt   <= 7'd0;
                    state <= CTRL;
                  end else begin
                    id  <= {id[CAN_ID_BITS-2:0], rx_bit};
                    cnt <= cnt + 7'd1;
                  end
                end
                CTRL: begin
                  case (cnt)
                    7'd0: begin
                      if (rx_bit) begin
                        form_err <= 1'b1;
                        busy     <= 1'b0;
                        state    <= WAIT_IDLE;
                        idle_cnt <= '0;
                      end else begin
                        cnt <= cnt + 7'd1;
                      end
                    end
                    7'd1: cnt <= cnt + 7'd1;
                    default: begin
                      dlc <= {dlc[2:0], rx_bit};
                      if (cnt == 7'd5) begin
                        pay_len <= next_len;
                        cnt     <= 7'd0;
                        state   <= (next_len == 7'd0) ? CRC : DATA;
                      end else begin
                        cnt <= cnt + 7'd1;
                      end
                    end
                  endcase
                end
                DATA: begin
                  if (cnt == pay_len - 7'd1) begin
                    cnt   <= 7'd0;
                    state <= CRC;
                  end else begin
                    cnt <= cnt + 7'd1;
                  end
                end
                CRC: begin
                  rx_crc <= {rx_crc[CRC_BITS-2:0], rx_bit};
                  if (cnt == 7'(CRC_BITS - 1)) begin
                    cnt   <= 7'd0;
                    state <= DELIM;
                  end else begin
                    cnt <= cnt + 7'd1;
                  end
                end
                default: ;
              endcase
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_can_rx_frame_seq.sv
// Randomised bench for can_rx_frame_seq: frames are built and stuffed by a bit-list model,
// expected pulses go into a scoreboard queue that a negedge monitor drains.
module tb_can_rx_frame_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        bit_valid = 1'b0;
  logic        rx_bit = 1'b1;
  logic        busy, frame_done, crc_ok, stuff_err, form_err;
  logic [10:0] id;
  logic [3:0]  dlc;

  always #5 clk = ~clk;

  can_rx_frame_seq dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bit_valid  (bit_valid),
    .rx_bit     (rx_bit),
    .busy       (busy),
    .frame_done (frame_done),
    .crc_ok     (crc_ok),
    .id         (id),
    .dlc        (dlc),
    .stuff_err  (stuff_err),
    .form_err   (form_err)
  );

  typedef struct {
    int          kind;   // 0 done, 1 stuff error, 2 form error
    logic [10:0] id;
    logic [3:0]  dlc;
    logic        ok;
    int          at;     // strobe number of the causing bit
  } exp_t;

  exp_t        expq[$];
  bit          raw[$];
  bit          wq[$];
  int          map[$];
  int          n_chk = 0;
  int          n_fail = 0;
  int          issued = 0;
  int          strobe_cnt = 0;
  logic [10:0] cur_id;
  logic [3:0]  cur_dlc;
  logic        cur_ok;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic send_bit(input bit b);
    bit_valid = 1'b1;
    rx_bit    = b;
    issued++;
    @(negedge clk);
    bit_valid = 1'b0;
    rx_bit    = 1'b1;
    if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 2)) @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) send_bit(1'b1);
  endtask

  task automatic send_wire(input int from, input int to);
    for (int i = from; i < to; i++) send_bit(wq[i]);
  endtask

  // Unstuffed field list -> CRC -> stuffed wire bits with a raw-to-wire index map.
  task automatic build(input logic [10:0] fid, input bit frtr, input bit fide,
                       input logic [3:0] fdlc, input logic [63:0] fdata,
                       input bit flip, input bit delim);
    logic [14:0] c;
    logic [14:0] tx;
    int          nb;
    int          run;
    int          k;
    bit          last;
    raw.delete(); wq.delete(); map.delete();
    raw.push_back(1'b0);
    for (int i = 10; i >= 0; i--) raw.push_back(fid[i]);
    raw.push_back(frtr);
    raw.push_back(fide);
    raw.push_back(1'b0);
    for (int i = 3; i >= 0; i--) raw.push_back(fdlc[i]);
    nb = frtr ? 0 : 8 * ((fdlc > 4'd8) ? 8 : int'(fdlc));
    for (int i = 0; i < nb; i++) raw.push_back(fdata[63-i]);
    c = 15'h0;
    foreach (raw[i]) c = {c[13:0], 1'b0} ^ ((c[14] ^ raw[i]) ? 15'h4599 : 15'h0);
    tx = c;
    if (flip) begin
      k = $urandom_range(0, 14);
      tx[k] = ~tx[k];
    end
    for (int i = 14; i >= 0; i--) raw.push_back(tx[i]);
    cur_id  = fid;
    cur_dlc = fdlc;
    cur_ok  = (tx == c);
    last = raw[0];
    run  = 0;
    foreach (raw[i]) begin
      if (i > 0 && run == 5) begin
        last = !last;
        wq.push_back(last);
        run = 1;
      end
      map.push_back(wq.size());
      wq.push_back(raw[i]);
      if (i > 0 && raw[i] == last) run++;
      else begin
        last = raw[i];
        run  = 1;
      end
    end
    wq.push_back(delim);
  endtask

  task automatic push_exp(input int kind, input int offset);
    exp_t e;
    e.kind = kind;
    e.id   = cur_id;
    e.dlc  = cur_dlc;
    e.ok   = cur_ok;
    e.at   = issued + offset + 1;
    expq.push_back(e);
  endtask

  task automatic good_frame(input logic [10:0] fid, input bit frtr, input logic [3:0] fdlc);
    build(fid, frtr, 1'b0, fdlc, {$urandom, $urandom}, 1'b0, 1'b1);
    push_exp(0, wq.size() - 1);
    send_wire(0, wq.size());
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_frame_done"}, 32'(frame_done), 0);
    chk({tag, "_crc_ok"}, 32'(crc_ok), 0);
    chk({tag, "_stuff_err"}, 32'(stuff_err), 0);
    chk({tag, "_form_err"}, 32'(form_err), 0);
    chk({tag, "_id"}, 32'(id), 0);
    chk({tag, "_dlc"}, 32'(dlc), 0);
  endtask

  always @(posedge clk) if (bit_valid) strobe_cnt <= strobe_cnt + 1;

  always @(negedge clk) begin : monitor
    exp_t e;
    int   act_kind;
    if (frame_done || stuff_err || form_err) begin
      chk("pulse_exclusive", 32'(frame_done) + 32'(stuff_err) + 32'(form_err), 1);
      chk("busy_low_at_end", 32'(busy), 0);
      act_kind = frame_done ? 0 : (stuff_err ? 1 : 2);
      if (expq.size() == 0) begin
        chk("unexpected_pulse", 32'(act_kind) + 32'd1, 0);
      end else begin
        e = expq.pop_front();
        chk("pulse_kind", 32'(act_kind), 32'(e.kind));
        chk("pulse_bit_index", 32'(strobe_cnt), 32'(e.at));
        if (e.kind == 0) begin
          chk("done_id", 32'(id), 32'(e.id));
          chk("done_dlc", 32'(dlc), 32'(e.dlc));
          chk("done_crc_ok", 32'(crc_ok), 32'(e.ok));
        end
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // All-zero frame: stuffing throughout, CRC of zero.
    idle(11);
    build(11'h000, 1'b0, 1'b0, 4'd0, 64'h0, 1'b0, 1'b1);
    push_exp(0, wq.size() - 1);
    send_wire(0, wq.size());
    idle(11);
    chk("crc_ok_held", 32'(crc_ok), 1);
    chk("dlc_held", 32'(dlc), 0);

    // Same frame with a corrupted CRC bit; crc_ok must clear at SOF.
    build(11'h000, 1'b0, 1'b0, 4'd0, 64'h0, 1'b1, 1'b1);
    push_exp(0, wq.size() - 1);
    send_wire(0, 20);
    chk("crc_ok_cleared_at_sof", 32'(crc_ok), 0);
    chk("busy_mid_frame", 32'(busy), 1);
    send_wire(20, wq.size());

    // Missing stuff bit after SOF + five zeros.
    idle(11);
    push_exp(1, 5);
    repeat (6) send_bit(1'b0);
    chk("busy_after_stuff_err", 32'(busy), 0);

    // Dominant delimiter, then a frame right away that must be ignored.
    idle(11);
    build(11'h7FF, 1'b0, 1'b0, 4'd1, {8'hA5, 56'h0}, 1'b0, 1'b0);
    push_exp(2, wq.size() - 1);
    send_wire(0, wq.size());
    build(11'($urandom), 1'b0, 1'b0, 4'd2, {$urandom, $urandom}, 1'b0, 1'b1);
    send_wire(0, wq.size());
    idle(11);
    good_frame(11'h7FF, 1'b0, 4'd1);

    // IDE=1 is a form error at the IDE bit.
    idle(11);
    build(11'($urandom), 1'b0, 1'b1, 4'($urandom), {$urandom, $urandom}, 1'b0, 1'b1);
    push_exp(2, map[13]);
    send_wire(0, wq.size());

    // DLC 15 carries 64 payload bits; still busy just before the delimiter.
    idle(11);
    build(11'($urandom), 1'b0, 1'b0, 4'd15, {$urandom, $urandom}, 1'b0, 1'b1);
    push_exp(0, wq.size() - 1);
    send_wire(0, wq.size() - 1);
    chk("busy_before_delim_dlc15", 32'(busy), 1);
    send_wire(wq.size() - 1, wq.size());

    // Remote frame: no payload regardless of DLC.
    idle(11);
    good_frame(11'($urandom), 1'b1, 4'd5);

    // Reset in the middle of the payload.
    idle(11);
    build(11'($urandom), 1'b0, 1'b0, 4'd8, {$urandom, $urandom}, 1'b0, 1'b1);
    send_wire(0, map[19] + 10);
    chk("busy_before_reset", 32'(busy), 1);
    rst_n = 1'b0;
    #1;
    check_all_zero("mid_frame_reset");
    @(negedge clk);
    rst_n = 1'b1;
    send_wire(0, wq.size());
    idle(11);
    good_frame(11'($urandom), 1'b0, 4'($urandom));

    // Random traffic with occasional CRC corruption.
    for (int n = 0; n < 20; n++) begin
      idle(11);
      build(11'($urandom), ($urandom_range(0, 3) == 0), 1'b0, 4'($urandom),
            {$urandom, $urandom}, ($urandom_range(0, 3) == 0), 1'b1);
      push_exp(0, wq.size() - 1);
      send_wire(0, wq.size());
    end

    repeat (10) @(negedge clk);
    chk("leftover_expectations", 32'(expq.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
